// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the receiver and the transmitter:
// default frame geometry, the receiver state encoding and a small voting helper.
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  // 2-of-3 vote, used when the receiver filters single-tick spikes.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// RESET_VAL sets what both flops hold during reset (1 for an idle-high line).
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; q is safe to use in the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_BITS data bits (LSB first), 1 stop bit.
// The receiver is timed by an external sample strobe (en) running at OVERSAMPLE x baud.
// Optional build macro UART_RX_MAJORITY_EN: every start/data/stop decision becomes a
// 2-of-3 vote over the ticks just before, at and just after the bit centre. The decision
// then lands one tick later. Without the macro, a single sample is taken at the centre.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | line idle, looking for a low level on an en tick
// ST_START | timing to the middle of the start bit to confirm it
// ST_DATA  | sampling data bits at their centres, shifting in LSB first
// ST_STOP  | sampling the stop bit; high = good frame, low = framing error
// ST_BREAK | stop bit was low; waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rxdata,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the tick after the centre, so the start check moves one tick later.
  // Each later bit is a full bit period from there, so all decisions stay one tick late.
  localparam logic [CNT_W-1:0] START_TC = CNT_W'(OVERSAMPLE / 2);
`else
  localparam logic [CNT_W-1:0] START_TC = CNT_W'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 load, ferr;
  logic                 rx_s;
  logic                 sample;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_pin),
    .q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist[0] is rx_s from the previous en tick and hist[1] is from the tick before that.
  logic [1:0] hist;

  // Record rx_s on each en tick, so a vote can use the two earlier ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b11;
    end else if (en) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = maj3(hist[1], hist[0], rx_s);
`else
  assign sample = rx_s;
`endif

  assign rx_busy = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, counter and shift logic. Nothing changes on cycles without en.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    load         = 1'b0;
    ferr         = 1'b0;
    if (en) begin
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_next = ST_START;
            cnt_next   = '0;
          end
        end
        ST_START: begin
          if (cnt == START_TC) begin
            cnt_next     = '0;
            bit_idx_next = '0;
            state_next   = sample ? ST_IDLE : ST_DATA;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == BIT_TC) begin
            cnt_next   = '0;
            shreg_next = DATA_BITS'({sample, shreg} >> 1);
            if (bit_idx == LAST_IDX) begin
              state_next = ST_STOP;
            end else begin
              bit_idx_next = bit_idx + IDX_W'(1);
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt == BIT_TC) begin
            cnt_next = '0;
            if (sample) begin
              load       = 1'b1;
              state_next = ST_IDLE;
            end else begin
              ferr       = 1'b1;
              state_next = ST_BREAK;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath registers. The status pulses last one cycle, even if en stays low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rxdata    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      bit_idx   <= bit_idx_next;
      shreg     <= shreg_next;
      rx_valid  <= load;
      frame_err <= ferr;
      if (load) begin
        rxdata <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx using a scoreboard.
// The stimulus pushes each expected output into a queue. A monitor pops an entry and
// compares it whenever rx_valid or frame_err pulses.
// en pulses every 4 clocks. rx_pin changes just after an en tick, so the two-flop
// synchronizer makes each new level visible on the next en tick.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          rx_pin;
  logic [DB-1:0] rxdata;
  logic          rx_valid;
  logic          rx_busy;
  logic          frame_err;

  typedef struct {
    bit            is_err;
    logic [DB-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   div    = 0;
  bit   prev_pulse = 1'b0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rx_pin    (rx_pin),
    .rxdata    (rxdata),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Free-running en strobe, one clock in four.
  initial begin
    en = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      en  = (div == 0);
    end
  end

  // Monitor: pop the next expectation and compare it on every valid or error pulse.
  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      checks++;
      if (rx_valid && frame_err) begin
        errors++;
        $display("FAIL both_pulses: rx_valid=%b frame_err=%b, required only one high", rx_valid, frame_err);
      end
      checks++;
      if (prev_pulse) begin
        errors++;
        $display("FAIL pulse_width: pulse high for two cycles, required one-cycle pulse");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: rx_valid=%b frame_err=%b rxdata=%h, required no output",
                 rx_valid, frame_err, rxdata);
      end else begin
        cur = exp_q.pop_front();
        if (cur.is_err != frame_err || rxdata !== cur.data) begin
          errors++;
          $display("FAIL sb_compare: got frame_err=%b rxdata=%h, required frame_err=%b rxdata=%h",
                   frame_err, rxdata, cur.is_err, cur.data);
        end
      end
    end
    prev_pulse = rx_valid || frame_err;
  end

  // Watchdog: the stimulus should end long before this time.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    do @(posedge clk); while (en !== 1'b1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_drain(input string name);
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected outputs missing, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic push_valid(input logic [DB-1:0] d);
    exp_q.push_back('{is_err: 1'b0, data: d});
  endtask

  task automatic push_err(input logic [DB-1:0] held);
    exp_q.push_back('{is_err: 1'b1, data: held});
  endtask

  // One frame, starting right after an en tick. With spike=1, each data bit is
  // inverted for the single tick that the receiver treats as the bit centre.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input bit spike);
    rx_pin = 1'b0;
    idle(OS);
    for (int i = 0; i < DB; i++) begin
      if (spike) begin
        rx_pin = d[i];
        idle(OS / 2);
        rx_pin = ~d[i];
        idle(1);
        rx_pin = d[i];
        idle(OS / 2 - 1);
      end else begin
        rx_pin = d[i];
        idle(OS);
      end
    end
    rx_pin = stop;
    idle(OS);
  endtask

  initial begin
    logic [DB-1:0] v;
    rst    = 1'b1;
    rx_pin = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_rxdata", 32'(rxdata), 32'h0);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(rx_busy), 32'h0);
    rst = 1'b0;
    tick();

    // Single clean frame.
    push_valid(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(16);
    check_drain("drain_a5");

    // Back-to-back frames with no idle gap.
    push_valid(8'h00);
    push_valid(8'hFF);
    push_valid(8'h3C);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(16);
    check_drain("drain_b2b");

    // A low glitch of 5 ticks is rejected as a false start.
    rx_pin = 1'b0;
    idle(3);
    chk("glitch_busy", 32'(rx_busy), 32'h1);
    idle(2);
    rx_pin = 1'b1;
    idle(16);
    chk("glitch_idle", 32'(rx_busy), 32'h0);
    check_drain("drain_glitch");

    // Stop bit low, then the line is held low: one frame error, and rxdata keeps 0x3C.
    push_err(8'h3C);
    send_frame(8'h55, 1'b0, 1'b0);
    idle(40 * OS);
    chk("break_busy", 32'(rx_busy), 32'h1);
    rx_pin = 1'b1;
    idle(32);
    chk("break_exit", 32'(rx_busy), 32'h0);
    push_valid(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(16);
    check_drain("drain_break");

    // Reset in the middle of bit 4 of 0x81; 0x81 gives no output, then 0x7E is received.
    v = 8'h81;
    rx_pin = 1'b0;
    idle(OS);
    for (int i = 0; i < 4; i++) begin
      rx_pin = v[i];
      idle(OS);
    end
    rx_pin = v[4];
    idle(OS / 2);
    rst    = 1'b1;
    rx_pin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_rxdata", 32'(rxdata), 32'h0);
    chk("midrst_busy", 32'(rx_busy), 32'h0);
    rst = 1'b0;
    idle(32);
    push_valid(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(16);
    check_drain("drain_midrst");

    // A one-tick inverted spike at each data-bit centre of 0xC3.
`ifdef UART_RX_MAJORITY_EN
    push_valid(8'hC3);
`else
    push_valid(8'h3C);
`endif
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(16);
    check_drain("drain_spike");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
